rfifo_fwft_out: RTL and testbench

//  Read-side output stage of the async FIFO, in the rclk domain.
//  - Sits between the read-pointer/empty logic, the dual-port memory read port, and the consumer.
//  - Turns the "rinc + rempty + raddr/rdata" interface into a first-word-fall-through valid/ready stream.
//  - Holds data in a 2-entry output buffer, so m_data is registered and full throughput holds under back-pressure.

---
 rtl/rfifo_fwft_out.sv | 97 +++++++++
 tb/tb_rfifo_fwft_out.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rfifo_fwft_out.sv
// rtl/rfifo_fwft_out.sv - async FIFO read-side first-word-fall-through output stage
// Two-entry output buffer with credit-based read issue so m_data stays registered at full rate.
module rfifo_fwft_out #(
  parameter int DSIZE = 8,
  parameter int RLAT  = 1
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic             arempty,
  output logic             rinc,
  input  logic [DSIZE-1:0] rdata,
  output logic             m_valid,
  output logic [DSIZE-1:0] m_data,
  input  logic             m_ready,
  output logic             m_aempty
);

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DSIZE-1:0] head_q, head_d;
  logic [DSIZE-1:0] tail_q, tail_d;
  logic             inflight_q, inflight_d;
  logic             pop;
  logic             cap;
  logic [1:0]       count;
  logic [2:0]       pending;

  assign count    = state_q;
  assign m_valid  = (state_q != S0);
  assign m_data   = head_q;
  assign pop      = m_valid & m_ready;

  // Words held plus words already requested, minus the one leaving this cycle.
  assign pending  = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
  assign rinc     = ~rempty & (pending < 3'd2);

  assign cap        = (RLAT == 0) ? rinc : inflight_q;
  assign inflight_d = (RLAT == 0) ? 1'b0 : rinc;
  assign m_aempty   = (count <= 2'd1) & (arempty | rempty);

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      S0: begin
        if (cap) begin
          head_d  = rdata;
          state_d = S1;
        end
      end
      S1: begin
        if (pop & cap) begin
          head_d = rdata;
        end else if (pop) begin
          state_d = S0;
        end else if (cap) begin
          tail_d  = rdata;
          state_d = S2;
        end
      end
      S2: begin
        // A capture without a pop here cannot happen: the credit rule caps pending at 2.
        if (pop) begin
          head_d = tail_q;
          if (cap) begin
            tail_d = rdata;
          end else begin
            state_d = S1;
          end
        end
      end
      default: state_d = S0;
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q    <= S0;
      head_q     <= '0;
      tail_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_rfifo_fwft_out.sv
// tb/tb_rfifo_fwft_out.sv - bench for rfifo_fwft_out, RLAT=0 and RLAT=1 instances side by side
// Instance g has RLAT=g and its own memory model; a monitor keeps word-occupancy and order models.
module tb_rfifo_fwft_out;

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic [1:0] gate;
  logic [1:0] rempty, arempty, rinc, m_valid, m_ready, m_aempty;
  logic [7:0] rdata  [2];
  logic [7:0] m_data [2];

  logic [7:0]  mem     [2][2048];
  logic [10:0] wr_ptr  [2];
  logic [10:0] rd_ptr  [2];
  logic [7:0]  rdq;

  int          nvec = 0;
  int          nerr = 0;
  int          cap_m   [2];
  int          pop_m   [2];
  bit          infl_m  [2];
  logic [10:0] exp_ptr [2];

  always #5 rclk = ~rclk;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    assign rempty[g]  = gate[g] | ~rrst_n | (wr_ptr[g] == rd_ptr[g]);
    assign arempty[g] = (wr_ptr[g] - rd_ptr[g]) <= 11'd1;
    rfifo_fwft_out #(.DSIZE(8), .RLAT(g)) u_dut (
      .rclk    (rclk),
      .rrst_n  (rrst_n),
      .rempty  (rempty[g]),
      .arempty (arempty[g]),
      .rinc    (rinc[g]),
      .rdata   (rdata[g]),
      .m_valid (m_valid[g]),
      .m_data  (m_data[g]),
      .m_ready (m_ready[g]),
      .m_aempty(m_aempty[g])
    );
  end

  // Memory read ports: instance 0 combinational, instance 1 registered.
  assign rdata[0] = mem[0][rd_ptr[0]];
  assign rdata[1] = rdq;

  always @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rd_ptr[0] <= wr_ptr[0];
      rd_ptr[1] <= wr_ptr[1];
      rdq       <= 8'h00;
    end else begin
      if (rinc[0]) rd_ptr[0] <= rd_ptr[0] + 11'd1;
      if (rinc[1]) begin
        rd_ptr[1] <= rd_ptr[1] + 11'd1;
        rdq       <= mem[1][rd_ptr[1]];
      end
    end
  end

  // Occupancy = words captured minus words accepted; order = memory order.
  always @(negedge rclk) begin : mon
    int occ;
    for (int g = 0; g < 2; g++) begin
      if (!rrst_n) begin
        cap_m[g]   = 0;
        pop_m[g]   = 0;
        infl_m[g]  = 1'b0;
        exp_ptr[g] = wr_ptr[g];
        nvec++;
        if (m_valid[g] !== 1'b0 || m_data[g] !== 8'h00 || rinc[g] !== 1'b0 || m_aempty[g] !== 1'b1) begin
          nerr++;
          $display("FAIL reset_hold inst%0d: valid=%b data=%h rinc=%b aempty=%b, required 0 00 0 1",
                   g, m_valid[g], m_data[g], rinc[g], m_aempty[g]);
        end
      end else begin
        occ = cap_m[g] - pop_m[g];
        nvec++;
        if (occ > 2) begin
          nerr++;
          $display("FAIL overflow inst%0d: occupancy=%0d, required <=2", g, occ);
        end
        nvec++;
        if (m_valid[g] !== (occ > 0)) begin
          nerr++;
          $display("FAIL m_valid inst%0d: got %b, required %b", g, m_valid[g], occ > 0);
        end
        nvec++;
        if (m_aempty[g] !== ((occ <= 1) && (arempty[g] || rempty[g]))) begin
          nerr++;
          $display("FAIL m_aempty inst%0d: got %b, required %b", g, m_aempty[g],
                   (occ <= 1) && (arempty[g] || rempty[g]));
        end
        nvec++;
        if (rinc[g] === 1'b1 && rempty[g] === 1'b1) begin
          nerr++;
          $display("FAIL rinc_while_empty inst%0d: rinc=1, required 0", g);
        end
        if (m_valid[g] && m_ready[g]) begin
          nvec++;
          if (m_data[g] !== mem[g][exp_ptr[g]]) begin
            nerr++;
            $display("FAIL order inst%0d: data=%h, required %h", g, m_data[g], mem[g][exp_ptr[g]]);
          end
          exp_ptr[g] = exp_ptr[g] + 11'd1;
          pop_m[g]++;
        end
        if (g == 1) begin
          cap_m[g] += int'(infl_m[g]);
          infl_m[g] = rinc[g];
        end else begin
          cap_m[g] += int'(rinc[g]);
        end
      end
    end
  end

  task automatic push(input int g, input logic [7:0] w);
    mem[g][wr_ptr[g]] = w;
    wr_ptr[g] = wr_ptr[g] + 11'd1;
  endtask

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic test_reset();
    rrst_n = 1'b0;
    gate = 2'b11;
    m_ready = 2'b00;
    repeat (3) step();
    @(negedge rclk);
    for (int g = 0; g < 2; g++) begin
      nvec++;
      if (rinc[g] !== 1'b0 || m_valid[g] !== 1'b0 || m_data[g] !== 8'h00 || m_aempty[g] !== 1'b1) begin
        nerr++;
        $display("FAIL reset_state inst%0d: rinc=%b valid=%b data=%h aempty=%b, required 0 0 00 1",
                 g, rinc[g], m_valid[g], m_data[g], m_aempty[g]);
      end
    end
    step();
    rrst_n = 1'b1;
    repeat (10) begin
      @(negedge rclk);
      for (int g = 0; g < 2; g++) begin
        nvec++;
        if (rinc[g] !== 1'b0 || m_valid[g] !== 1'b0) begin
          nerr++;
          $display("FAIL idle_after_reset inst%0d: rinc=%b valid=%b, required 0 0", g, rinc[g], m_valid[g]);
        end
      end
    end
  endtask

  task automatic test_single();
    step();
    push(0, 8'hA5);
    push(1, 8'hA5);
    m_ready = 2'b11;
    step();
    gate = 2'b00;
    for (int k = 0; k < 5; k++) begin
      @(negedge rclk);
      for (int g = 0; g < 2; g++) begin
        if (k == 0) begin
          nvec++;
          if (rinc[g] !== 1'b1) begin
            nerr++;
            $display("FAIL single_rinc inst%0d: rinc=%b, required 1", g, rinc[g]);
          end
        end
        nvec++;
        if (m_valid[g] !== (k == 1 + g)) begin
          nerr++;
          $display("FAIL single_latency inst%0d cycle+%0d: valid=%b, required %b", g, k, m_valid[g], k == 1 + g);
        end
        if (k == 1 + g) begin
          nvec++;
          if (m_data[g] !== 8'hA5) begin
            nerr++;
            $display("FAIL single_data inst%0d: data=%h, required a5", g, m_data[g]);
          end
        end
      end
    end
  endtask

  task automatic test_stream();
    int idx [2];
    bit started [2];
    idx = '{0, 0};
    started = '{1'b0, 1'b0};
    step();
    gate = 2'b11;
    for (int k = 0; k < 16; k++) begin
      push(0, 8'(k));
      push(1, 8'(k));
    end
    step();
    gate = 2'b00;
    for (int c = 0; c < 40; c++) begin
      @(negedge rclk);
      for (int g = 0; g < 2; g++) begin
        if (m_valid[g]) begin
          nvec++;
          if (m_data[g] !== 8'(idx[g])) begin
            nerr++;
            $display("FAIL stream_data inst%0d: data=%h, required %h", g, m_data[g], 8'(idx[g]));
          end
          idx[g]++;
          started[g] = 1'b1;
        end else if (started[g] && idx[g] < 16) begin
          nvec++;
          nerr++;
          $display("FAIL stream_bubble inst%0d: valid=0 after %0d words, required 1", g, idx[g]);
        end
      end
    end
    for (int g = 0; g < 2; g++) begin
      nvec++;
      if (idx[g] != 16) begin
        nerr++;
        $display("FAIL stream_count inst%0d: %0d words, required 16", g, idx[g]);
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [7:0] w [8];
    int got [2];
    got = '{0, 0};
    step();
    m_ready = 2'b00;
    gate = 2'b11;
    for (int k = 0; k < 8; k++) begin
      w[k] = 8'($urandom);
      push(0, w[k]);
      push(1, w[k]);
    end
    step();
    gate = 2'b00;
    for (int k = 0; k < 5; k++) begin
      @(negedge rclk);
      if (k >= 3) begin
        for (int g = 0; g < 2; g++) begin
          nvec++;
          if (rinc[g] !== 1'b0 || m_valid[g] !== 1'b1 || m_data[g] !== w[0]) begin
            nerr++;
            $display("FAIL backpressure_hold inst%0d: rinc=%b valid=%b data=%h, required 0 1 %h",
                     g, rinc[g], m_valid[g], m_data[g], w[0]);
          end
        end
      end
    end
    step();
    m_ready = 2'b11;
    for (int c = 0; c < 30; c++) begin
      @(negedge rclk);
      for (int g = 0; g < 2; g++) begin
        if (m_valid[g] && m_ready[g] && got[g] < 8) begin
          nvec++;
          if (m_data[g] !== w[got[g]]) begin
            nerr++;
            $display("FAIL backpressure_order inst%0d word%0d: data=%h, required %h", g, got[g], m_data[g], w[got[g]]);
          end
          got[g]++;
        end
      end
    end
    for (int g = 0; g < 2; g++) begin
      nvec++;
      if (got[g] != 8) begin
        nerr++;
        $display("FAIL backpressure_count inst%0d: %0d words, required 8", g, got[g]);
      end
    end
  endtask

  task automatic test_random();
    int pushed [2];
    int got [2];
    pushed = '{0, 0};
    got = '{0, 0};
    for (int c = 0; c < 20000 && (got[0] < 1000 || got[1] < 1000); c++) begin
      step();
      for (int g = 0; g < 2; g++) begin
        m_ready[g] = 1'($urandom_range(0, 1));
        gate[g] = ($urandom_range(0, 3) == 0);
        if (pushed[g] < 1000 && $urandom_range(0, 3) != 0) begin
          push(g, 8'($urandom));
          pushed[g]++;
        end
      end
      @(negedge rclk);
      for (int g = 0; g < 2; g++) begin
        if (m_valid[g] && m_ready[g]) got[g]++;
      end
    end
    for (int g = 0; g < 2; g++) begin
      nvec++;
      if (got[g] != 1000) begin
        nerr++;
        $display("FAIL random_count inst%0d: %0d words delivered, required 1000", g, got[g]);
      end
    end
    step();
    gate = 2'b00;
    m_ready = 2'b11;
    repeat (5) step();
  endtask

  task automatic test_reset_mid();
    bit seen [2];
    seen = '{1'b0, 1'b0};
    gate = 2'b00;
    m_ready = 2'b11;
    for (int k = 0; k < 6; k++) begin
      push(0, 8'h50 + 8'(k));
      push(1, 8'h50 + 8'(k));
    end
    repeat (3) step();
    m_ready = 2'b00;
    repeat (2) step();
    rrst_n = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      nvec++;
      if (m_valid[g] !== 1'b0 || m_data[g] !== 8'h00 || m_aempty[g] !== 1'b1) begin
        nerr++;
        $display("FAIL reset_async inst%0d: valid=%b data=%h aempty=%b, required 0 00 1",
                 g, m_valid[g], m_data[g], m_aempty[g]);
      end
    end
    repeat (3) step();
    rrst_n = 1'b1;
    m_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      push(0, 8'hC0 + 8'(k));
      push(1, 8'hC0 + 8'(k));
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge rclk);
      for (int g = 0; g < 2; g++) begin
        if (!seen[g] && m_valid[g]) begin
          seen[g] = 1'b1;
          nvec++;
          if (m_data[g] !== 8'hC0) begin
            nerr++;
            $display("FAIL reset_first_word inst%0d: data=%h, required c0", g, m_data[g]);
          end
        end
      end
    end
    for (int g = 0; g < 2; g++) begin
      nvec++;
      if (!seen[g]) begin
        nerr++;
        $display("FAIL reset_first_word_timeout inst%0d: no word within 12 cycles", g);
      end
    end
    repeat (8) step();
  endtask

  initial begin
    rrst_n = 1'b0;
    gate = 2'b11;
    m_ready = 2'b00;
    wr_ptr[0] = '0;
    wr_ptr[1] = '0;
    test_reset();
    test_single();
    test_stream();
    test_back_pressure();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
